btn_event_gen: RTL and testbench
================================

# btn_event_gen

Input-side front end for the front-panel up/down counter. It takes the two raw, asynchronous push-button lines and turns them into clean, single-cycle increment and decrement events that the counter consumes directly, so the counter never samples bouncing levels. Each channel has a synchronizer, a debounce counter, edge detection and optional hold-to-repeat. Sits between the board pins and the counter/LED display logic, in the same clock domain.

## Interface
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronized cycles required to accept a level change (10 ms at 25 MHz).
- REPEAT_DELAY, 12500000: cycles from the initial press event to the first auto-repeat event.
- REPEAT_RATE, 2500000: cycles between subsequent auto-repeat events.
- CNT_W, 24: width of the per-channel timing counter; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- btn_plus_raw  input  1  raw plus button, asynchronous, active-high.
- btn_minus_raw  input  1  raw minus button, asynchronous, active-high.
- inc_pulse  output  1  one-cycle increment event.
- dec_pulse  output  1  one-cycle decrement event.
- plus_held  output  1  debounced level of the plus button.
- minus_held  output  1  debounced level of the minus button.

## Operation
- Reset (reset==0 at a clock edge) clears all outputs to 0, both synchronizer stages to 0, the counters to 0, and the FSMs to IDLE.
- Synchronizer: 2 flops per channel. s = second stage.
- Debounce: counter is 0 while s == held. While s != held it increments. On the edge where it equals DEBOUNCE_CYCLES-1 and s != held: held <= s, counter <= 0. Any return of s to held before that clears the counter.
- Per-channel FSM states:
  - IDLE: held==0.
  - PRESSED: held rose. The press event fires on the same edge held goes 1.
  - REPEAT: hold-to-repeat timing.
  - Release (held falls) returns the FSM to IDLE from any state. No event on release.
- Priority: if inc and dec events fall on the same edge, only inc_pulse asserts and the dec event is dropped, not deferred.
- Events are exactly one cycle wide. There are never two consecutive high cycles on one output.

## Timing
- Raw press first sampled high at edge 0, held stable: held and the event appear at edge DEBOUNCE_CYCLES+2, giving latency DEBOUNCE_CYCLES+2 cycles.
- Release latency is the same, DEBOUNCE_CYCLES+2 cycles.
- Glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no change and no event.
- Reset mid-debounce: the count is discarded. A button held through reset release generates a fresh press event DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Repeat timer (when compiled in):
  - The timer reuses the channel counter, which restarts at 0 on the press edge.
  - First repeat event is REPEAT_DELAY cycles after the press event.
  - Later repeat events follow every REPEAT_RATE cycles while held==1.
  - Release cancels the timer immediately and wraps nothing.
- Counter arithmetic is unsigned CNT_W. It never wraps, because every compare terminates the count.

## Configuration
- BTN_AUTO_REPEAT_EN defined: REPEAT state active. Holding a button produces the press event plus periodic repeat events as timed above.
- BTN_AUTO_REPEAT_EN undefined: exactly one event per debounced press. The REPEAT state and repeat compare logic are not built. REPEAT_DELAY and REPEAT_RATE are ignored.

## Structure
- Shared package btn_pkg holds:
  - the channel FSM state enum (IDLE, PRESSED, REPEAT);
  - default timing constants (debounce, repeat delay, repeat rate at 25 MHz).
- Sub-module btn_channel: synchronizer, debounce counter, FSM and repeat timer for one button. It outputs held and event.
- The top instantiates btn_channel twice and applies plus-over-minus priority on the two events.

## Test plan
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, CNT_W=8.
- Clean press: btn_plus_raw high from edge 0 for 40 cycles, macro off -> inc_pulse high only in cycle 6; plus_held 1 from cycle 6 to 6 cycles after release; dec_pulse stays 0.
- Bounce: btn_minus_raw toggles every 2 cycles for 20 cycles, then stays high -> no event during toggling; single dec_pulse 6 cycles after the final rise.
- Simultaneous: both raw inputs rise on the same edge -> inc_pulse at cycle 6; dec_pulse never asserts; both held outputs 1.
- Auto-repeat with BTN_AUTO_REPEAT_EN, plus held for 60 cycles after acceptance -> inc_pulse at cycles 6, 26, 34, 42, 50, 58, 66; none after release.
- Reset mid-operation: reset low for 1 cycle at cycle 3 of a plus press, raw still high -> no event at cycle 6; inc_pulse 6 cycles after reset returns high.
- Reset values: reset low for 3 cycles with both raw inputs high -> all four outputs 0 throughout.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button front end (25 MHz board clock).
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;    // 10 ms
    localparam int DEFAULT_REPEAT_DELAY    = 12500000;  // 500 ms
    localparam int DEFAULT_REPEAT_RATE     = 2500000;   // 100 ms
    localparam int DEFAULT_CNT_W           = 24;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce counter and press FSM.
// Hold-to-repeat is built only when BTN_AUTO_REPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
`ifdef BTN_AUTO_REPEAT_EN
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE,
`endif
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic held,
    output logic evt
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_FIRST_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RPT_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
`endif

    logic             sync1_reg;
    logic             sync2_reg;
    logic             held_reg;
    logic             evt_reg;
    logic             db_active_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] db_cnt;
    btn_state_t       state_reg;

    // The counter is shared with the repeat timer, so a fresh mismatch always counts from 0.
    assign db_cnt = db_active_reg ? cnt_reg : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            held_reg      <= 1'b0;
            evt_reg       <= 1'b0;
            db_active_reg <= 1'b0;
            cnt_reg       <= '0;
            state_reg     <= IDLE;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            evt_reg   <= 1'b0;
            if (sync2_reg != held_reg) begin
                if (db_cnt == DB_LAST) begin
                    held_reg      <= sync2_reg;
                    cnt_reg       <= '0;
                    db_active_reg <= 1'b0;
                    if (sync2_reg) begin
                        state_reg <= PRESSED;
                        evt_reg   <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end else begin
                    cnt_reg       <= db_cnt + 1'b1;
                    db_active_reg <= 1'b1;
                end
            end else if (db_active_reg) begin
                // A glitch that did not survive debounce also restarts the repeat timer.
                cnt_reg       <= '0;
                db_active_reg <= 1'b0;
            end else begin
                case (state_reg)
`ifdef BTN_AUTO_REPEAT_EN
                    PRESSED: begin
                        if (cnt_reg == RPT_FIRST_LAST) begin
                            evt_reg   <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= REPEAT;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (cnt_reg == RPT_RATE_LAST) begin
                            evt_reg <= 1'b1;
                            cnt_reg <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
`endif
                    default: cnt_reg <= '0;
                endcase
            end
        end
    end

    assign held = held_reg;
    assign evt  = evt_reg;

endmodule

// File: rtl/btn_event_gen.sv
// Two debounced button channels producing increment/decrement events; plus wins a tie.
// Optional hold-to-repeat: define BTN_AUTO_REPEAT_EN.
module btn_event_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEFAULT_REPEAT_RATE,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_plus_raw,
    input  logic btn_minus_raw,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic plus_held,
    output logic minus_held
);

    localparam int TIMING_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

    generate
        if (TIMING_MAX > (2 ** CNT_W) - 1) begin : g_cnt_w_check
            $error("CNT_W too narrow for the configured timing");
        end
    endgenerate

    // Index 0 is the plus channel, index 1 the minus channel.
    logic [1:0] raw_vec;
    logic [1:0] held_vec;
    logic [1:0] evt_vec;

    assign raw_vec = {btn_minus_raw, btn_plus_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            btn_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef BTN_AUTO_REPEAT_EN
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
`endif
                .CNT_W           (CNT_W)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .btn_raw (raw_vec[gi]),
                .held    (held_vec[gi]),
                .evt     (evt_vec[gi])
            );
        end
    endgenerate

    // A coincident decrement is dropped, not deferred.
    assign inc_pulse  = evt_vec[0];
    assign dec_pulse  = evt_vec[1] & ~evt_vec[0];
    assign plus_held  = held_vec[0];
    assign minus_held = held_vec[1];

endmodule

// File: tb/tb_btn_event_gen.sv
// Directed bench for btn_event_gen with short timing (debounce 4, repeat 20/8).
module tb_btn_event_gen;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_plus_raw = 1'b0;
    logic btn_minus_raw = 1'b0;
    logic inc_pulse, dec_pulse, plus_held, minus_held;

    int checks_cnt = 0;
    int errors_cnt = 0;

    btn_event_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8),
        .CNT_W           (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .btn_plus_raw  (btn_plus_raw),
        .btn_minus_raw (btn_minus_raw),
        .inc_pulse     (inc_pulse),
        .dec_pulse     (dec_pulse),
        .plus_held     (plus_held),
        .minus_held    (minus_held)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 ns after it and new inputs take effect from the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Press at cycle 0 is accepted at cycle 6; repeats (if built) at 26, 34, ... while the
    // synchronized level is still high, i.e. up to two edges after the raw release.
    function automatic logic exp_inc(input int k, input int rel);
        logic r;
        r = (k == 6);
`ifdef BTN_AUTO_REPEAT_EN
        if (k >= 26 && ((k - 26) % 8) == 0 && k <= rel + 2) r = 1'b1;
`endif
        return r;
    endfunction

    initial begin
        // Reset values with both buttons pressed.
        btn_plus_raw  = 1'b1;
        btn_minus_raw = 1'b1;
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("rst_inc@%0d", k), 32'(inc_pulse), 0);
            chk($sformatf("rst_dec@%0d", k), 32'(dec_pulse), 0);
            chk($sformatf("rst_ph@%0d", k), 32'(plus_held), 0);
            chk($sformatf("rst_mh@%0d", k), 32'(minus_held), 0);
        end
        btn_plus_raw  = 1'b0;
        btn_minus_raw = 1'b0;
        step();
        reset = 1'b1;
        idle(10);
        $display("reset values done");

        // Clean press, 40 cycles.
        btn_plus_raw = 1'b1;
        for (int k = 1; k <= 52; k++) begin
            step();
            chk($sformatf("clean_inc@%0d", k), 32'(inc_pulse), 32'(exp_inc(k, 40)));
            chk($sformatf("clean_held@%0d", k), 32'(plus_held), 32'(k >= 6 && k < 46));
            chk($sformatf("clean_dec@%0d", k), 32'(dec_pulse), 0);
            if (k == 40) btn_plus_raw = 1'b0;
        end
        $display("clean press done");
        idle(4);

        // Bounce on minus: toggle every 2 cycles for 20 cycles, then stay high.
        btn_minus_raw = 1'b1;
        for (int k = 1; k <= 35; k++) begin
            step();
            chk($sformatf("bounce_dec@%0d", k), 32'(dec_pulse), 32'(k == 26));
            chk($sformatf("bounce_held@%0d", k), 32'(minus_held), 32'(k >= 26));
            if (k < 20) btn_minus_raw = ((k / 2) % 2) == 0;
            else btn_minus_raw = 1'b1;
        end
        btn_minus_raw = 1'b0;
        idle(12);
        chk("bounce_release", 32'(minus_held), 0);
        $display("bounce done");

        // Simultaneous press: plus wins, the minus event is dropped.
        btn_plus_raw  = 1'b1;
        btn_minus_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            chk($sformatf("simul_inc@%0d", k), 32'(inc_pulse), 32'(k == 6));
            chk($sformatf("simul_dec@%0d", k), 32'(dec_pulse), 0);
            chk($sformatf("simul_ph@%0d", k), 32'(plus_held), 32'(k >= 6));
            chk($sformatf("simul_mh@%0d", k), 32'(minus_held), 32'(k >= 6));
        end
        btn_plus_raw  = 1'b0;
        btn_minus_raw = 1'b0;
        idle(12);
        $display("simultaneous done");

        // Long hold: 60 cycles after acceptance, then release.
        btn_plus_raw = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step();
            chk($sformatf("hold_inc@%0d", k), 32'(inc_pulse), 32'(exp_inc(k, 66)));
            chk($sformatf("hold_held@%0d", k), 32'(plus_held), 32'(k >= 6 && k < 72));
            if (k == 66) btn_plus_raw = 1'b0;
        end
        $display("hold done");
        idle(4);

        // Reset pulse at cycle 3 of a plus press discards the debounce count.
        btn_plus_raw = 1'b1;
        idle(2);
        reset = 1'b0;
        step();
        chk("midrst_inc@3", 32'(inc_pulse), 0);
        chk("midrst_held@3", 32'(plus_held), 0);
        reset = 1'b1;
        for (int k = 4; k <= 16; k++) begin
            step();
            chk($sformatf("midrst_inc@%0d", k), 32'(inc_pulse), 32'(k == 9));
            chk($sformatf("midrst_held@%0d", k), 32'(plus_held), 32'(k >= 9));
        end
        btn_plus_raw = 1'b0;
        idle(12);
        chk("midrst_release", 32'(plus_held), 0);
        $display("reset mid-press done");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
